// File: rtl/brew_unit.sv
// brew_unit -- coffee-maker side of the MAKE handshake.
// Answers the control unit's Making/Coffee levels with Done/TakeOut and sequences
// the pump, heater and milk valve for one cup.  Dispensing pauses while the
// debounced cup sensor reports no cup, and resumes where it stopped.
//
// Ports
//   CLK        system clock
//   RST        synchronous active-high reset
//   Making     brew request level from control, held until Done is seen
//   Coffee     cup-removal wait level from control, held until TakeOut is seen
//   KindSel    drink kind: 01 Americano, 10 Ratte, 00/11 invalid
//   CupRaw     raw asynchronous cup sensor, 1 = cup in place
//   Done       cup finished, held until Making falls
//   TakeOut    cup removed, held until Coffee falls
//   Pump       water pump on
//   Heater     heater on
//   MilkValve  milk valve open
//   CupLight   "take your cup" lamp (also lit while waiting for a cup)
//   Fault      sticky invalid-kind flag, cleared only by RST
module brew_unit #(
  parameter int FILL_CYC = 8,
  parameter int AM_CYC   = 20,
  parameter int MILK_CYC = 12,
  parameter int DEB_CYC  = 4,
  parameter int CNT_W    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Making,
  input  logic       Coffee,
  input  logic [1:0] KindSel,
  input  logic       CupRaw,
  output logic       Done,
  output logic       TakeOut,
  output logic       Pump,
  output logic       Heater,
  output logic       MilkValve,
  output logic       CupLight,
  output logic       Fault
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CUPWAIT = 4'd1,
    ST_FILL    = 4'd2,
    ST_BREW    = 4'd3,
    ST_MILK    = 4'd4,
    ST_FAULT   = 4'd5,
    ST_DONE    = 4'd6,
    ST_SERVE   = 4'd7,
    ST_TAKEN   = 4'd8
  } state_t;

  localparam logic [1:0]       KIND_AM    = 2'b01;
  localparam logic [1:0]       KIND_RATTE = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] AM_LAST    = CNT_W'(AM_CYC - 1);
  localparam logic [CNT_W-1:0] MILK_LAST  = CNT_W'(MILK_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYC - 1);

  state_t           state_r;
  state_t           ret_r;
  state_t           step_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] step_cnt_s;
  logic [1:0]       kind_r;
  logic             sync1_r;
  logic             sync2_r;
  logic             cup_r;
  logic [CNT_W-1:0] deb_cnt_r;

  // Cup sensor: two-flop synchronizer, then a consecutive-sample debouncer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      cup_r     <= 1'b0;
      deb_cnt_r <= CNT_ZERO;
    end else begin
      sync1_r <= CupRaw;
      sync2_r <= sync1_r;
      if (sync2_r == cup_r) begin
        deb_cnt_r <= CNT_ZERO;
      end else if (deb_cnt_r == DEB_LAST) begin
        cup_r     <= sync2_r;
        deb_cnt_r <= CNT_ZERO;
      end else begin
        deb_cnt_r <= deb_cnt_r + CNT_ONE;
      end
    end
  end

  // One step of the timed phases: where the phase goes and what the counter
  // becomes if this cycle is consumed as a dispensing cycle.
  always_comb begin
    step_state_s = state_r;
    step_cnt_s   = cnt_r + CNT_ONE;
    case (state_r)
      ST_FILL: begin
        if (cnt_r == FILL_LAST) begin
          step_state_s = ST_BREW;
          step_cnt_s   = CNT_ZERO;
        end else begin
          step_state_s = ST_FILL;
        end
      end
      ST_BREW: begin
        if (cnt_r == AM_LAST) begin
          step_state_s = (kind_r == KIND_RATTE) ? ST_MILK : ST_DONE;
          step_cnt_s   = CNT_ZERO;
        end else begin
          step_state_s = ST_BREW;
        end
      end
      ST_MILK: begin
        if (cnt_r == MILK_LAST) begin
          step_state_s = ST_DONE;
          step_cnt_s   = CNT_ZERO;
        end else begin
          step_state_s = ST_MILK;
        end
      end
      default: begin
        step_state_s = state_r;
        step_cnt_s   = cnt_r;
      end
    endcase
  end

  // Main sequencer with registered outputs decoded from the current state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      ret_r     <= ST_FILL;
      kind_r    <= 2'b00;
      cnt_r     <= CNT_ZERO;
      Done      <= 1'b0;
      TakeOut   <= 1'b0;
      Pump      <= 1'b0;
      Heater    <= 1'b0;
      MilkValve <= 1'b0;
      CupLight  <= 1'b0;
      Fault     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Making) begin
            kind_r <= KindSel;
            cnt_r  <= CNT_ZERO;
            ret_r  <= ST_FILL;
            if ((KindSel != KIND_AM) && (KindSel != KIND_RATTE)) begin
              state_r <= ST_FAULT;
            end else if (cup_r) begin
              state_r <= ST_FILL;
            end else begin
              state_r <= ST_CUPWAIT;
            end
          end
        end
        ST_CUPWAIT: begin
          if (!Making) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (cup_r) begin
            state_r <= ret_r;
          end
        end
        ST_FILL, ST_BREW, ST_MILK: begin
          if (!Making) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else begin
            // The cycle on which the cup is lost still dispensed, so it counts;
            // a pause then resumes at the stepped phase and count.  A phase
            // that finishes on that cycle has nothing left to pause.
            cnt_r <= step_cnt_s;
            if (!cup_r && (step_state_s != ST_DONE)) begin
              state_r <= ST_CUPWAIT;
              ret_r   <= step_state_s;
            end else begin
              state_r <= step_state_s;
            end
          end
        end
        ST_FAULT: begin
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (!Making) begin
            state_r <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (Coffee && !cup_r) begin
            state_r <= ST_TAKEN;
          end
        end
        ST_TAKEN: begin
          if (!Coffee) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase

      Pump      <= (state_r == ST_FILL) || (state_r == ST_BREW);
      Heater    <= (state_r == ST_FILL);
      MilkValve <= (state_r == ST_MILK);
      CupLight  <= (state_r == ST_CUPWAIT) || (state_r == ST_SERVE);
      Done      <= (state_r == ST_FAULT) || (state_r == ST_DONE);
      TakeOut   <= (state_r == ST_TAKEN);
      Fault     <= Fault | (state_r == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_brew_unit.sv
// Self-checking bench for brew_unit: a scoreboard queue holds the expected Done
// edge and actuator cycle counts for each cup, popped when Done rises.
module tb_brew_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Making = 1'b0;
  logic       Coffee = 1'b0;
  logic [1:0] KindSel = 2'b01;
  logic       CupRaw = 1'b1;
  logic       Done, TakeOut, Pump, Heater, MilkValve, CupLight, Fault;

  brew_unit dut (
    .CLK(CLK), .RST(RST), .Making(Making), .Coffee(Coffee), .KindSel(KindSel),
    .CupRaw(CupRaw), .Done(Done), .TakeOut(TakeOut), .Pump(Pump), .Heater(Heater),
    .MilkValve(MilkValve), .CupLight(CupLight), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int done_e;
    int heat_n;
    int pump_n;
    int milk_n;
    int first_heat;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   fail_cnt  = 0;
  int   edge_n    = 0;
  int   heat_cnt, pump_cnt, milk_cnt, first_heat_obs;
  bit   done_prev = 1'b0;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic push_exp(input int done_e, input int heat, input int pump,
                          input int milk, input int first_heat);
    exp_t e;
    e.done_e = done_e; e.heat_n = heat; e.pump_n = pump;
    e.milk_n = milk;   e.first_heat = first_heat;
    sb_q.push_back(e);
    heat_cnt = 0; pump_cnt = 0; milk_cnt = 0; first_heat_obs = -1;
  endtask

  // One clock edge; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    edge_n++;
    if (Heater) begin
      heat_cnt++;
      if (first_heat_obs < 0) first_heat_obs = edge_n;
    end
    if (Pump) pump_cnt++;
    if (MilkValve) milk_cnt++;
    if (Done && !done_prev) begin
      if (sb_q.size() == 0) begin
        check_val("done_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_val("done_edge", edge_n, e.done_e);
        check_val("heater_cycles", heat_cnt, e.heat_n);
        check_val("pump_cycles", pump_cnt, e.pump_n);
        check_val("milk_cycles", milk_cnt, e.milk_n);
        check_val("first_heat_edge", first_heat_obs, e.first_heat);
      end
    end
    done_prev = Done;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check_val("done_timeout", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Serve handshake: drop Making, remove cup with Coffee high, then release.
  task automatic finish_cup();
    int n = 0;
    Making = 1'b0;
    tick(); tick();
    check_val("cuplight_serve", int'(CupLight), 1);
    check_val("done_low_after_making", int'(Done), 0);
    Coffee = 1'b1;
    CupRaw = 1'b0;
    while (!TakeOut && n < 30) begin
      tick();
      n++;
    end
    check_val("takeout_latency", n, 8);
    Coffee = 1'b0;
    tick(); tick();
    check_val("takeout_low", int'(TakeOut), 0);
    CupRaw = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    RST = 1'b0;
    check_val("reset_outputs",
              int'({Done, TakeOut, Pump, Heater, MilkValve, CupLight, Fault}), 0);
    repeat (10) tick();

    // Americano with a 3-cycle sensor glitch during BREW (no effect expected).
    KindSel = 2'b01;
    Making  = 1'b1;
    push_exp(edge_n + 1 + 29, 8, 28, 0, edge_n + 2);
    repeat (15) tick();
    CupRaw = 1'b0;
    repeat (3) tick();
    CupRaw = 1'b1;
    wait_done();
    finish_cup();

    // Ratte: milk phase after brew.
    KindSel = 2'b10;
    Making  = 1'b1;
    push_exp(edge_n + 1 + 41, 8, 28, 12, edge_n + 2);
    wait_done();
    finish_cup();

    // No cup: wait in CUPWAIT with the lamp on, then insert the cup.
    KindSel = 2'b01;
    CupRaw  = 1'b0;
    repeat (10) tick();
    Making = 1'b1;
    heat_cnt = 0; pump_cnt = 0; milk_cnt = 0;
    repeat (6) tick();
    check_val("cupwait_light", int'(CupLight), 1);
    check_val("cupwait_no_act", heat_cnt + pump_cnt + milk_cnt, 0);
    CupRaw = 1'b1;
    push_exp(edge_n + 7 + 29, 8, 28, 0, edge_n + 8);
    wait_done();
    finish_cup();

    // Cup removed 5 cycles into BREW for 12 cycles: Done delayed by 12.
    Making = 1'b1;
    push_exp(edge_n + 1 + 29 + 12, 8, 28, 0, edge_n + 2);
    repeat (1 + 8 + 5) tick();
    CupRaw = 1'b0;
    repeat (12) tick();
    check_val("pause_pump_off", int'(Pump), 0);
    check_val("pause_light", int'(CupLight), 1);
    CupRaw = 1'b1;
    wait_done();
    finish_cup();

    // Making dropped mid-FILL: back to IDLE, actuators off, no Done.
    Making = 1'b1;
    repeat (4) tick();
    check_val("fill_heater_on", int'(Heater), 1);
    Making = 1'b0;
    tick(); tick();
    check_val("abort_act_off", int'({Pump, Heater, MilkValve}), 0);
    repeat (40) tick();
    check_val("abort_no_done", int'(Done), 0);

    // Reset in the middle of MILK.
    KindSel = 2'b10;
    Making  = 1'b1;
    n = 0;
    while (!MilkValve && n < 100) begin
      tick();
      n++;
    end
    check_val("milk_reached", int'(MilkValve), 1);
    repeat (3) tick();
    RST    = 1'b1;
    Making = 1'b0;
    tick();
    check_val("rst_mid_milk_outs",
              int'({Done, TakeOut, Pump, Heater, MilkValve, CupLight, Fault}), 0);
    RST = 1'b0;
    repeat (10) tick();

    // Invalid kind: Fault and Done with no actuation; Fault survives handshake.
    KindSel = 2'b00;
    Making  = 1'b1;
    push_exp(edge_n + 2, 0, 0, 0, -1);
    wait_done();
    check_val("fault_set", int'(Fault), 1);
    finish_cup();
    check_val("fault_sticky", int'(Fault), 1);
    KindSel = 2'b01;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    check_val("fault_cleared", int'(Fault), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
